// File: rtl/risc_pkg.sv
// Shared widths, constants and fetch FSM state type for the IITB RISC front end.
package risc_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // Sequential PC successor; wraps FFFF -> 0000 by width truncation.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO with clear. Push while full is accepted only
// when a pop happens in the same cycle, so the head is read before it is
// overwritten.
module fetch_queue #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // Occupancy for this cycle's push/pop/clear combination.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 2'd0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage, read/write pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (clr_i) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (do_push) begin
                    mem_q[wr_ptr_q] <= push_data_i;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (do_pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, request issue, in-order response tagging,
// 2-entry prefetch queue and the IF/ID register feeding decode.
// Note: resetn is active-HIGH despite its name (1 = in reset).
//
// state | meaning
// FETCH | issuing requests while issue credit is available
// DRAIN | after a redirect, discarding stale in-flight responses; no requests
module instr_fetch
    import risc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int              MAX_OUT  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               id_flush
);

    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

    fetch_state_e         state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [1:0]           drop_cnt_q, drop_cnt_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      instr_pc_q, instr_pc_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 id_flush_q;

    logic [PC_W+INSTR_W-1:0] q_head;
    logic [1:0]              q_count;
    logic                    q_push, q_pop, q_clr;

    // The tag FIFO holds the PC of every accepted request not yet answered,
    // so its occupancy is the outstanding-request count.
    logic [PC_W-1:0] tag_head;
    logic [1:0]      out_cnt;
    logic            req_fire;
    logic            rsp_take;
    logic            load_en;
    logic            credit;

    fetch_queue #(.W(PC_W + INSTR_W)) u_pfq (
        .clk         (clk),
        .rst         (resetn),
        .clr_i       (q_clr),
        .push_i      (q_push),
        .push_data_i ({tag_head, imem_rsp_data}),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    fetch_queue #(.W(PC_W)) u_tagq (
        .clk         (clk),
        .rst         (resetn),
        .clr_i       (1'b0),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (imem_rsp_valid),
        .head_o      (tag_head),
        .count_o     (out_cnt)
    );

    assign credit         = ({1'b0, out_cnt} + {1'b0, q_count}) < MAX_OUT_C;
    assign imem_req_valid = !resetn && (state_q == FETCH) && !redirect && credit;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_addr      = pc_q;
    assign rsp_take       = imem_rsp_valid && (drop_cnt_q == 2'd0) && !redirect;
    assign load_en        = !stall || !instr_valid_q;

    // Next-state, PC, drop counter, IF/ID load and queue control.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_cnt_d    = drop_cnt_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        q_push        = 1'b0;
        q_pop         = 1'b0;
        q_clr         = 1'b0;

        if (redirect) begin
            pc_d          = redirect_pc;
            q_clr         = 1'b1;
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            drop_cnt_d    = out_cnt - {1'b0, imem_rsp_valid};
            state_d       = (drop_cnt_d != 2'd0) ? DRAIN : FETCH;
        end else begin
            if (req_fire) begin
                pc_d = pc_next(pc_q);
            end
            if (imem_rsp_valid && (drop_cnt_q != 2'd0)) begin
                drop_cnt_d = drop_cnt_q - 2'd1;
            end
            if ((state_q == DRAIN) && (drop_cnt_d == 2'd0)) begin
                state_d = FETCH;
            end

            if (load_en) begin
                if (q_count != 2'd0) begin
                    {instr_pc_d, instr_d} = q_head;
                    instr_valid_d         = 1'b1;
                    q_pop                 = 1'b1;
                    q_push                = rsp_take;
                end else if (rsp_take) begin
                    // Empty queue: a fresh response goes straight to IF/ID.
                    instr_pc_d    = tag_head;
                    instr_d       = imem_rsp_data;
                    instr_valid_d = 1'b1;
                end else begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                end
            end else begin
                q_push = rsp_take;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, drop counter, IF/ID register and flush pulse.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            pc_q          <= RESET_PC;
            drop_cnt_q    <= 2'd0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            id_flush_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            drop_cnt_q    <= drop_cnt_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            id_flush_q    <= redirect;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign id_flush    = id_flush_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with programmable latency,
// expected-instruction queue filled by the stimulus, monitor that pops and
// compares every instruction decode consumes.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        id_flush;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .id_flush       (id_flush)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    k_lat    = 1;
    int    cyc      = 0;
    int    wait_n;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory image is mem[a] = 16'h1000 + a.
    task automatic push_run(input logic [15:0] start, input int n);
        logic [15:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: p, data: p + 16'h1000});
            p = p + 16'd1;
        end
    endtask

    // Memory model: records accepted requests, answers in order k_lat cycles later.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (resetn) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 16'h0000;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_q[0].addr + 16'h1000;
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 16'hDEAD;
            end
            @(negedge clk);
            if (!resetn && imem_req_valid && imem_req_ready)
                pend_q.push_back('{due: cyc + k_lat, addr: imem_addr});
        end
    end

    // Monitor: every instruction consumed by decode must be the next expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn && instr_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h instr %h, required no instruction", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr_pc", {16'h0, instr_pc}, {16'h0, e.pc});
                    check("sb_instr", {16'h0, instr}, {16'h0, e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn         = 1'b1;
        imem_req_ready = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 16'h0000;
        k_lat          = 1;

        // Reset values.
        repeat (3) tick();
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_addr", {16'h0, imem_addr}, 32'h0);
        check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", {16'h0, instr}, 32'h0);
        check("rst_instr_pc", {16'h0, instr_pc}, 32'h0);
        check("rst_id_flush", {31'h0, id_flush}, 32'h0);

        // Streaming with k = 1: addresses 0,1,2,3; instr 1000 then 1001.
        push_run(16'h0000, 32);
        resetn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            check("stream_req_valid", {31'h0, imem_req_valid}, 32'h1);
            check("stream_addr", {16'h0, imem_addr}, i);
        end
        check("stream_instr_1001", {16'h0, instr}, 32'h1001);
        check("stream_instr_pc_1", {16'h0, instr_pc}, 32'h1);

        // Stall 5 cycles with 1001 held.
        stall = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j >= 1) check("stall_req_stop", {31'h0, imem_req_valid}, 32'h0);
            check("stall_hold_instr", {16'h0, instr}, 32'h1001);
            check("stall_hold_valid", {31'h0, instr_valid}, 32'h1);
        end
        check("stall_hold_pc", {16'h0, instr_pc}, 32'h1);
        stall = 1'b0;
        tick();
        check("release_1002", {16'h0, instr}, 32'h1002);
        tick();
        check("release_1003", {16'h0, instr}, 32'h1003);
        tick();
        check("release_1004", {16'h0, instr}, 32'h1004);
        check("release_pc_4", {16'h0, instr_pc}, 32'h4);

        // Redirect to 0x40 with two outstanding, k = 3.
        k_lat  = 3;
        wait_n = 0;
        while ((imem_req_valid || imem_rsp_valid) && wait_n < 20) begin
            tick();
            wait_n++;
        end
        check("p3_saturate_timeout", {31'h0, (wait_n < 20)}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        exp_q.delete();
        push_run(16'h0040, 32);
        tick();
        redirect = 1'b0;
        check("p3_id_flush", {31'h0, id_flush}, 32'h1);
        check("p3_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("p3_instr_nop", {16'h0, instr}, 32'h0);
        check("p3_drain_req0", {31'h0, imem_req_valid}, 32'h0);
        tick();
        check("p3_flush_pulse_end", {31'h0, id_flush}, 32'h0);
        check("p3_drain_req1", {31'h0, imem_req_valid}, 32'h0);
        tick();
        check("p3_fetch_req", {31'h0, imem_req_valid}, 32'h1);
        check("p3_fetch_addr", {16'h0, imem_addr}, 32'h40);
        wait_n = 0;
        while (exp_q.size() > 29 && wait_n < 40) begin
            tick();
            wait_n++;
        end
        check("p3_stream_timeout", {31'h0, (wait_n < 40)}, 32'h1);

        // Redirect with stall and response in the same cycle; target near wrap.
        stall  = 1'b1;
        wait_n = 0;
        while (!imem_rsp_valid && wait_n < 10) begin
            tick();
            wait_n++;
        end
        check("p4_rsp_timeout", {31'h0, (wait_n < 10)}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        #1;
        check("p4_no_req_on_redirect", {31'h0, imem_req_valid}, 32'h0);
        exp_q.delete();
        push_run(16'hFFFE, 30);
        tick();
        redirect = 1'b0;
        check("p4_id_flush", {31'h0, id_flush}, 32'h1);
        check("p4_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("p4_instr_nop", {16'h0, instr}, 32'h0);
        stall  = 1'b0;
        wait_n = 0;
        while (exp_q.size() > 26 && wait_n < 60) begin
            tick();
            wait_n++;
        end
        check("p4_wrap_timeout", {31'h0, (wait_n < 60)}, 32'h1);
        check("p4_wrap_pc", {16'h0, instr_pc}, 32'h1);

        // Reset while draining two stale responses.
        wait_n = 0;
        while ((imem_req_valid || imem_rsp_valid) && wait_n < 20) begin
            tick();
            wait_n++;
        end
        check("p5_saturate_timeout", {31'h0, (wait_n < 20)}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        exp_q.delete();
        tick();
        redirect = 1'b0;
        check("p5_flush_before_rst", {31'h0, id_flush}, 32'h1);
        #1;
        resetn = 1'b1;
        #1;
        check("p5_rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("p5_rst_addr", {16'h0, imem_addr}, 32'h0);
        check("p5_rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("p5_rst_instr", {16'h0, instr}, 32'h0);
        check("p5_rst_instr_pc", {16'h0, instr_pc}, 32'h0);
        check("p5_rst_id_flush", {31'h0, id_flush}, 32'h0);
        tick();
        tick();
        k_lat = 1;
        push_run(16'h0000, 32);
        resetn = 1'b0;
        #1;
        check("p5_resume_req", {31'h0, imem_req_valid}, 32'h1);
        check("p5_resume_addr", {16'h0, imem_addr}, 32'h0);
        wait_n = 0;
        while (exp_q.size() > 29 && wait_n < 20) begin
            tick();
            wait_n++;
        end
        check("p5_resume_timeout", {31'h0, (wait_n < 20)}, 32'h1);
        stall = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
